// File: rtl/hqm_aw_rf_256x20_fifo_ctl.sv
// Show-ahead FIFO controller over a 256x20 two-port RF with 1-cycle read latency.
// Zero-fills the RF after reset, then schedules pushes/prefetch reads into a 2-entry skid.
module hqm_aw_rf_256x20_fifo_ctl #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DWIDTH = 20,
  parameter int unsigned AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic              pop_valid,
  output logic [DWIDTH-1:0] pop_data,
  output logic              full,
  output logic [AWIDTH:0]   count,
  output logic              init_done,
  output logic              err_push,
  output logic              err_pop,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata
);

  localparam int unsigned CW = AWIDTH + 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [AWIDTH-1:0] wptr_q, rptr_q;
  logic [CW-1:0]     mem_cnt_q, count_q, count_d;
  logic              rd_inflight_q;
  logic [1:0]        skid_cnt_q;
  logic [DWIDTH-1:0] skid0_q, skid1_q;
  logic              full_q, err_push_q, err_pop_q;

  logic              push_acc_c, pop_fire_c, rd_issue_c;
  logic [1:0]        skid_occ_c, skid_base_c;

  assign init_done  = (state_q == RUN);
  assign pop_valid  = (skid_cnt_q != 2'd0);
  assign pop_data   = skid0_q;
  assign full       = full_q;
  assign count      = count_q;
  assign err_push   = err_push_q;
  assign err_pop    = err_pop_q;

  assign push_acc_c = push & init_done & ~full_q;
  assign pop_fire_c = pop & pop_valid;

  // Skid occupancy after this cycle's pop plus the read already in flight.
  assign skid_occ_c  = skid_cnt_q + 2'(rd_inflight_q) - 2'(pop_fire_c);
  assign skid_base_c = skid_cnt_q - 2'(pop_fire_c);
  assign rd_issue_c  = init_done & (mem_cnt_q != '0) & ~skid_occ_c[1];
  assign count_d     = count_q + CW'(push_acc_c) - CW'(pop_fire_c);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state and RF port drive
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = wptr_q;
    mem_wdata  = push_data;
    mem_re     = 1'b0;
    mem_raddr  = rptr_q;
    case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = '0;
        init_cnt_d = init_cnt_q + AWIDTH'(1);
        if (init_cnt_q == AWIDTH'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mem_we = push_acc_c;
        mem_re = rd_issue_c;
      end
    endcase
  end

  // Pointers, occupancy and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      mem_cnt_q     <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      rd_inflight_q <= 1'b0;
      skid_cnt_q    <= 2'd0;
      err_push_q    <= 1'b0;
      err_pop_q     <= 1'b0;
    end else begin
      wptr_q        <= wptr_q + AWIDTH'(push_acc_c);
      rptr_q        <= rptr_q + AWIDTH'(rd_issue_c);
      mem_cnt_q     <= mem_cnt_q + CW'(push_acc_c) - CW'(rd_issue_c);
      count_q       <= count_d;
      full_q        <= (count_d == CW'(DEPTH));
      rd_inflight_q <= rd_issue_c;
      skid_cnt_q    <= skid_occ_c;
      err_push_q    <= push & ~push_acc_c;
      err_pop_q     <= pop & ~pop_valid;
    end
  end

  // Skid data: shift on pop, then land returning RF data behind the survivors
  always_ff @(posedge clk) begin
    if (rst) begin
      skid0_q <= '0;
      skid1_q <= '0;
    end else begin
      if (pop_fire_c) begin
        skid0_q <= skid1_q;
      end
      if (rd_inflight_q) begin
        if (skid_base_c[0]) begin
          skid1_q <= mem_rdata;
        end else begin
          skid0_q <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_hqm_aw_rf_256x20_fifo_ctl.sv
// Bench for the RF-backed show-ahead FIFO controller: RF behavioural model,
// scoreboard queue for pushed data, vector table for the first-pop timeline.
module tb_hqm_aw_rf_256x20_fifo_ctl;

  logic        clk;
  logic        rst;
  logic        push;
  logic [19:0] push_data;
  logic        pop;
  logic        pop_valid;
  logic [19:0] pop_data;
  logic        full;
  logic [8:0]  count;
  logic        init_done;
  logic        err_push;
  logic        err_pop;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [19:0] mem_wdata;
  logic        mem_re;
  logic [7:0]  mem_raddr;
  logic [19:0] mem_rdata;

  hqm_aw_rf_256x20_fifo_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .full      (full),
    .count     (count),
    .init_done (init_done),
    .err_push  (err_push),
    .err_pop   (err_pop),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: 1-cycle read latency
  logic [19:0] rf [256];
  always @(posedge clk) begin
    if (mem_we) rf[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= rf[mem_raddr];
  end

  int          checks   = 0;
  int          failures = 0;
  logic [8:0]  m_count;
  logic        m_ready;
  logic [7:0]  m_wptr, m_rptr;
  logic [19:0] sb [$];
  logic        last_re;

  typedef struct {
    logic        push;
    logic [19:0] data;
    logic        pop;
    logic        exp_pv;
    logic        exp_re;
    logic [8:0]  exp_cnt;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1
  task automatic do_cycle(input logic p, input logic [19:0] d, input logic q);
    logic        acc, fire;
    logic [19:0] exp_d;
    push = p; push_data = d; pop = q;
    #1;
    acc  = p && m_ready && (m_count != 9'd256);
    fire = q && pop_valid;
    last_re = mem_re;
    if (m_ready) begin
      chk("mem_we", 32'(mem_we), 32'(acc));
      if (mem_re) begin
        chk("mem_raddr", 32'(mem_raddr), 32'(m_rptr));
        m_rptr = m_rptr + 8'd1;
      end
    end
    if (acc) begin
      chk("mem_waddr", 32'(mem_waddr), 32'(m_wptr));
      chk("mem_wdata", 32'(mem_wdata), 32'(d));
      sb.push_back(d);
      m_wptr = m_wptr + 8'd1;
    end
    if (fire) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL pop_unexpected: got %0h expected no data", pop_data);
      end else begin
        exp_d = sb.pop_front();
        chk("pop_data", 32'(pop_data), 32'(exp_d));
      end
    end
    @(posedge clk); #1;
    m_count = m_count + 9'(acc) - 9'(fire);
    chk("count", 32'(count), 32'(m_count));
    chk("full", 32'(full), 32'(m_count == 9'd256));
    chk("err_push", 32'(err_push), 32'(p && !acc));
    chk("err_pop", 32'(err_pop), 32'(q && !fire));
    push = 1'b0; pop = 1'b0;
  endtask

  // Release reset and walk the zero-fill sweep; a push and a pop are thrown in
  task automatic run_init();
    m_count = '0; m_ready = 1'b0; m_wptr = '0; m_rptr = '0; sb.delete();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      push = (i == 10); push_data = 20'hABCDE; pop = (i == 20);
      #1;
      chk("init_we", 32'(mem_we), 32'd1);
      chk("init_waddr", 32'(mem_waddr), 32'(i));
      chk("init_wdata", 32'(mem_wdata), 32'd0);
      chk("init_re", 32'(mem_re), 32'd0);
      chk("init_done_low", 32'(init_done), 32'd0);
      chk("init_count", 32'(count), 32'd0);
      @(posedge clk); #1;
      chk("init_err_push", 32'(err_push), 32'(i == 10));
      chk("init_err_pop", 32'(err_pop), 32'(i == 20));
    end
    push = 1'b0; pop = 1'b0;
    chk("init_done_rise", 32'(init_done), 32'd1);
    m_ready = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && m_count != 0; k++) do_cycle(1'b0, '0, 1'b1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_sb", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 20'h00001, 1'b0, 1'b0, 1'b0, 9'd1};
    vecs[1] = '{1'b1, 20'h00002, 1'b0, 1'b0, 1'b1, 9'd2};
    vecs[2] = '{1'b1, 20'h00003, 1'b0, 1'b0, 1'b1, 9'd3};
    vecs[3] = '{1'b1, 20'h00004, 1'b1, 1'b1, 1'b1, 9'd3};
    vecs[4] = '{1'b1, 20'h00005, 1'b1, 1'b1, 1'b1, 9'd3};
    vecs[5] = '{1'b0, 20'h00000, 1'b1, 1'b1, 1'b1, 9'd2};
    vecs[6] = '{1'b0, 20'h00000, 1'b1, 1'b1, 1'b0, 9'd1};
    vecs[7] = '{1'b0, 20'h00000, 1'b1, 1'b1, 1'b0, 9'd0};
    vecs[8] = '{1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 9'd0};

    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    m_count = '0; m_ready = 1'b0; m_wptr = '0; m_rptr = '0; last_re = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_err_push", 32'(err_push), 32'd0);
    chk("rst_err_pop", 32'(err_pop), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd1);
    chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    run_init();

    // First-pop latency and ordering from an empty FIFO
    foreach (vecs[i]) begin
      chk("vec_pop_valid", 32'(pop_valid), 32'(vecs[i].exp_pv));
      do_cycle(vecs[i].push, vecs[i].data, vecs[i].pop);
      chk("vec_mem_re", 32'(last_re), 32'(vecs[i].exp_re));
      chk("vec_count", 32'(count), 32'(vecs[i].exp_cnt));
    end

    // Fill to capacity, overflow push, push+pop while full
    for (int k = 0; k < 256; k++) do_cycle(1'b1, 20'(k + 100), 1'b0);
    chk("full_count", 32'(count), 32'd256);
    chk("full_flag", 32'(full), 32'd1);
    do_cycle(1'b1, 20'h00BAD, 1'b0);
    chk("overflow_we", 32'(last_re & 1'b0 | mem_we), 32'd0);
    chk("overflow_err", 32'(err_push), 32'd1);
    chk("full_pv", 32'(pop_valid), 32'd1);
    do_cycle(1'b1, 20'h0BAD2, 1'b1);
    chk("full_pushpop_count", 32'(count), 32'd255);
    chk("full_pushpop_err", 32'(err_push), 32'd1);
    drain();

    // Empty pop leaves state alone
    do_cycle(1'b0, '0, 1'b1);
    chk("empty_err_pop", 32'(err_pop), 32'd1);
    chk("empty_count", 32'(count), 32'd0);
    do_cycle(1'b0, '0, 1'b0);
    chk("empty_err_pop_clear", 32'(err_pop), 32'd0);

    // Half-full streaming across pointer wrap
    for (int k = 0; k < 128; k++) do_cycle(1'b1, 20'(k * 7 + 3), 1'b0);
    repeat (4) do_cycle(1'b0, '0, 1'b0);
    for (int k = 0; k < 1000; k++) begin
      chk("no_bubble", 32'(pop_valid), 32'd1);
      do_cycle(1'b1, 20'(k + 32'h50000), 1'b1);
    end
    chk("stream_count", 32'(count), 32'd128);
    drain();

    // Reset with data in the skid and a read in flight
    do_cycle(1'b1, 20'h11111, 1'b0);
    do_cycle(1'b1, 20'h22222, 1'b0);
    do_cycle(1'b1, 20'h33333, 1'b0);
    chk("pre_rst_pv", 32'(pop_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_pv", 32'(pop_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_init_done", 32'(init_done), 32'd0);
    chk("mid_rst_waddr", 32'(mem_waddr), 32'd0);
    run_init();
    for (int k = 0; k < 10; k++) begin
      do_cycle(1'b0, '0, 1'b0);
      chk("no_stale_pv", 32'(pop_valid), 32'd0);
    end
    do_cycle(1'b1, 20'h12345, 1'b0);
    repeat (6) do_cycle(1'b0, '0, 1'b1);
    chk("post_rst_sb", 32'(sb.size()), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
